// File: rtl/i8035_ext_bus_resp.sv
// External-bus target for the 8035 sound CPU: latches the low address on ALE, serves
// PSENn fetches from a synchronous ROM, MOVX reads via req/ack and MOVX writes as strobes.
module i8035_ext_bus_resp #(
    parameter int         ROM_AW  = 11,
    parameter logic [7:0] DB_IDLE = 8'hFF
) (
    input  logic              I_CLK,
    input  logic              I_RSTn,
    input  logic              I_ALE,
    input  logic              I_PSENn,
    input  logic              I_RDn,
    input  logic              I_WRn,
    input  logic [7:0]        I_DB,
    input  logic [7:0]        I_P2,
    output logic [7:0]        O_DB,
    output logic              O_DB_OE,
    output logic [ROM_AW-1:0] O_ROM_A,
    output logic              O_ROM_RE,
    input  logic [7:0]        I_ROM_D,
    output logic [7:0]        O_XD_A,
    output logic              O_XRD_REQ,
    input  logic              I_XRD_ACK,
    input  logic [7:0]        I_XRD_D,
    output logic              O_XWR_STB,
    output logic [7:0]        O_XWR_D,
    output logic              O_CONFLICT,
    output logic              O_LATE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_A,
        S_FETCH_D,
        S_DRIVE,
        S_XRD_WAIT,
        S_XWR
    } state_t;

    state_t              state_q;
    logic                ale_q, psen_q, rd_q, wr_q;
    logic [7:0]          addr_lo_q, addr_lo_d;
    logic [7:0]          db_q, xwr_d_q;
    logic                oe_q, rom_re_q, xrd_req_q, xwr_stb_q;
    logic                conflict_q, late_q;
    logic                src_rd_q, ack_arm_q;
    logic [ROM_AW-1:0]   rom_a_q;

    logic ale_fall, psen_fall, rd_fall, wr_fall;
    logic multi_low, strobe_hi;
    logic unused_p2;

    assign ale_fall  = ale_q  & ~I_ALE;
    assign psen_fall = psen_q & ~I_PSENn;
    assign rd_fall   = rd_q   & ~I_RDn;
    assign wr_fall   = wr_q   & ~I_WRn;

    assign multi_low = (~I_PSENn & ~I_RDn) | (~I_PSENn & ~I_WRn) | (~I_RDn & ~I_WRn);

    // An ALE fall coinciding with a strobe fall must already use the new address.
    assign addr_lo_d = ale_fall ? I_DB : addr_lo_q;

    assign strobe_hi = src_rd_q ? I_RDn : I_PSENn;

    // Upper P2 bits are not part of the ROM address for narrower ROMs.
    assign unused_p2 = ^I_P2;

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q    <= S_IDLE;
            // Strobe history resets "low" so a strobe held low across reset is not a fall.
            ale_q      <= 1'b0;
            psen_q     <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_lo_q  <= 8'h00;
            db_q       <= 8'h00;
            xwr_d_q    <= 8'h00;
            oe_q       <= 1'b0;
            rom_re_q   <= 1'b0;
            xrd_req_q  <= 1'b0;
            xwr_stb_q  <= 1'b0;
            conflict_q <= 1'b0;
            late_q     <= 1'b0;
            src_rd_q   <= 1'b0;
            ack_arm_q  <= 1'b0;
            rom_a_q    <= '0;
        end else begin
            ale_q     <= I_ALE;
            psen_q    <= I_PSENn;
            rd_q      <= I_RDn;
            wr_q      <= I_WRn;
            addr_lo_q <= addr_lo_d;
            rom_re_q  <= 1'b0;
            xrd_req_q <= 1'b0;
            xwr_stb_q <= 1'b0;

            if (multi_low) begin
                conflict_q <= 1'b1;
            end

            if (I_ALE && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                late_q  <= 1'b1;
                oe_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (psen_fall) begin
                            rom_a_q  <= {I_P2[ROM_AW-9:0], addr_lo_d};
                            rom_re_q <= 1'b1;
                            src_rd_q <= 1'b0;
                            state_q  <= S_FETCH_A;
                        end else if (rd_fall) begin
                            xrd_req_q <= 1'b1;
                            src_rd_q  <= 1'b1;
                            ack_arm_q <= 1'b0;
                            state_q   <= S_XRD_WAIT;
                        end else if (wr_fall) begin
                            xwr_d_q <= I_DB;
                            state_q <= S_XWR;
                        end
                    end
                    S_FETCH_A: begin
                        if (I_PSENn) begin
                            late_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_FETCH_D;
                        end
                    end
                    S_FETCH_D: begin
                        if (I_PSENn) begin
                            late_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            db_q    <= I_ROM_D;
                            oe_q    <= 1'b1;
                            state_q <= S_DRIVE;
                        end
                    end
                    S_XRD_WAIT: begin
                        if (I_RDn) begin
                            late_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            // ACK in the same cycle as REQ is not accepted.
                            ack_arm_q <= 1'b1;
                            if (ack_arm_q && I_XRD_ACK) begin
                                db_q    <= I_XRD_D;
                                oe_q    <= 1'b1;
                                state_q <= S_DRIVE;
                            end
                        end
                    end
                    S_DRIVE: begin
                        if (strobe_hi) begin
                            oe_q    <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                    S_XWR: begin
                        if (I_WRn) begin
                            xwr_stb_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            xwr_d_q <= I_DB;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign O_DB       = oe_q ? db_q : DB_IDLE;
    assign O_DB_OE    = oe_q;
    assign O_ROM_A    = rom_a_q;
    assign O_ROM_RE   = rom_re_q;
    assign O_XD_A     = addr_lo_q;
    assign O_XRD_REQ  = xrd_req_q;
    assign O_XWR_STB  = xwr_stb_q;
    assign O_XWR_D    = xwr_d_q;
    assign O_CONFLICT = conflict_q;
    assign O_LATE     = late_q;

endmodule

// File: tb/tb_i8035_ext_bus_resp.sv
// Bench for i8035_ext_bus_resp: vector table, randomized transactions against a
// transaction-level model, and hand sequences for abort and reset corners.
module tb_i8035_ext_bus_resp;
    localparam int ROM_AW = 11;

    logic              clk = 1'b0;
    logic              I_RSTn, I_ALE, I_PSENn, I_RDn, I_WRn, I_XRD_ACK;
    logic [7:0]        I_DB, I_P2, I_XRD_D, I_ROM_D;
    logic [7:0]        O_DB, O_XD_A, O_XWR_D;
    logic              O_DB_OE, O_ROM_RE, O_XRD_REQ, O_XWR_STB, O_CONFLICT, O_LATE;
    logic [ROM_AW-1:0] O_ROM_A;

    i8035_ext_bus_resp #(.ROM_AW(ROM_AW), .DB_IDLE(8'hFF)) dut (
        .I_CLK(clk), .I_RSTn(I_RSTn), .I_ALE(I_ALE), .I_PSENn(I_PSENn), .I_RDn(I_RDn),
        .I_WRn(I_WRn), .I_DB(I_DB), .I_P2(I_P2), .O_DB(O_DB), .O_DB_OE(O_DB_OE),
        .O_ROM_A(O_ROM_A), .O_ROM_RE(O_ROM_RE), .I_ROM_D(I_ROM_D), .O_XD_A(O_XD_A),
        .O_XRD_REQ(O_XRD_REQ), .I_XRD_ACK(I_XRD_ACK), .I_XRD_D(I_XRD_D),
        .O_XWR_STB(O_XWR_STB), .O_XWR_D(O_XWR_D), .O_CONFLICT(O_CONFLICT), .O_LATE(O_LATE)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data one clock after the read enable.
    logic [7:0] rom [0:(1<<ROM_AW)-1];
    always @(posedge clk) if (O_ROM_RE) I_ROM_D <= rom[O_ROM_A];

    typedef struct {
        int kind;               // 0 fetch, 1 MOVX read, 2 MOVX write
        logic [7:0] addr;
        logic [7:0] p2;
        int w;                  // clocks the strobe is sampled low
        int d;                  // ACK delay after REQ
        logic [7:0] xd;
        bit same_edge;
        bit dual;
    } txn_t;

    typedef struct {
        int re; int req; int stb; int oe; int first;
        logic [7:0] data;
        bit late; bit conf;
    } exp_t;

    typedef struct { txn_t t; exp_t e; } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc, re_cnt, re_cyc, req_cnt, req_cyc, stb_cnt, stb_cyc, oe_cnt, oe_first, oe_d_chg, bad_idle;
    logic [ROM_AW-1:0] rom_a_seen;
    logic [7:0] xa_seen, stb_d_seen, oe_d_first;
    logic [7:0] db_seq [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        cyc = 0; re_cnt = 0; re_cyc = 0; req_cnt = 0; req_cyc = 0; stb_cnt = 0; stb_cyc = 0;
        oe_cnt = 0; oe_first = 0; oe_d_chg = 0; bad_idle = 0;
        rom_a_seen = '0; xa_seen = 0; stb_d_seen = 0; oe_d_first = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (O_ROM_RE)  begin re_cnt++;  re_cyc = cyc;  rom_a_seen = O_ROM_A; end
        if (O_XRD_REQ) begin req_cnt++; req_cyc = cyc; xa_seen = O_XD_A; end
        if (O_XWR_STB) begin stb_cnt++; stb_cyc = cyc; stb_d_seen = O_XWR_D; end
        if (O_DB_OE) begin
            oe_cnt++;
            if (oe_first == 0) begin oe_first = cyc; oe_d_first = O_DB; end
            else if (O_DB !== oe_d_first) oe_d_chg++;
        end else if (O_DB !== 8'hFF) begin
            bad_idle++;
        end
    endtask

    task automatic do_reset();
        I_RSTn = 1'b0; I_ALE = 1'b0; I_PSENn = 1'b1; I_RDn = 1'b1; I_WRn = 1'b1;
        I_XRD_ACK = 1'b0; I_XRD_D = 8'h00;
        step(); step();
        I_RSTn = 1'b1;
        step();
    endtask

    task automatic latch_addr(input logic [7:0] a, input logic [7:0] p2);
        I_P2 = p2; I_DB = a; I_ALE = 1'b1; step();
        I_ALE = 1'b0; step();
    endtask

    // Expected outcome from the bus rules: fetch needs the strobe low through the
    // data-capture clock, a read needs RDn low when ACK is sampled.
    function automatic exp_t model(input txn_t t);
        exp_t e;
        e.re = (t.kind == 0) ? 1 : 0;
        e.req = (t.kind == 1) ? 1 : 0;
        e.stb = (t.kind == 2) ? 1 : 0;
        e.oe = 0; e.first = 0; e.data = 8'h00; e.late = 1'b0; e.conf = t.dual;
        if (t.kind == 0) begin
            if (t.w >= 3) begin e.oe = t.w - 2; e.first = 3; e.data = rom[{t.p2[ROM_AW-9:0], t.addr}]; end
            else e.late = 1'b1;
        end else if (t.kind == 1) begin
            if (t.w > t.d + 1) begin e.oe = t.w - t.d - 1; e.first = t.d + 2; e.data = t.xd; end
            else e.late = 1'b1;
        end else begin
            e.data = db_seq[t.w - 1];
        end
        return e;
    endfunction

    task automatic run_txn(input txn_t t, input exp_t e, input string tag);
        logic [ROM_AW-1:0] ea;
        int n;
        ea = {t.p2[ROM_AW-9:0], t.addr};
        I_P2 = t.p2; I_DB = t.addr; I_ALE = 1'b1; step();
        if (!t.same_edge) begin I_ALE = 1'b0; step(); end
        I_ALE = 1'b0;
        if (t.kind == 2 && !t.same_edge) I_DB = db_seq[0];
        I_PSENn = !(t.kind == 0);
        I_RDn   = !(t.kind == 1 || t.dual);
        I_WRn   = !(t.kind == 2);
        clear_mon();
        n = t.w + t.d + 6;
        for (int k = 1; k <= n; k++) begin
            step();
            if (k == t.w) begin I_PSENn = 1'b1; I_RDn = 1'b1; I_WRn = 1'b1; end
            else if (k < t.w && t.kind == 2) I_DB = db_seq[k];
            I_XRD_ACK = (t.kind == 1) && (k == t.d + 1 || k == t.d + 3);
            I_XRD_D = (k == t.d + 1) ? t.xd : ~t.xd;
        end
        chk({tag, " rom_re_count"}, re_cnt, e.re);
        if (e.re > 0) begin
            chk({tag, " rom_re_cycle"}, re_cyc, 1);
            chk({tag, " rom_addr"}, rom_a_seen, ea);
        end
        chk({tag, " xrd_req_count"}, req_cnt, e.req);
        if (e.req > 0) begin
            chk({tag, " xrd_req_cycle"}, req_cyc, 1);
            chk({tag, " xrd_addr"}, xa_seen, t.addr);
        end
        chk({tag, " xwr_stb_count"}, stb_cnt, e.stb);
        if (e.stb > 0) begin
            chk({tag, " xwr_stb_cycle"}, stb_cyc, t.w + 1);
            chk({tag, " xwr_data"}, stb_d_seen, e.data);
        end
        chk({tag, " oe_cycles"}, oe_cnt, e.oe);
        chk({tag, " oe_first"}, oe_first, e.first);
        if (e.oe > 0) begin
            chk({tag, " db_data"}, oe_d_first, e.data);
            chk({tag, " db_stable"}, oe_d_chg, 0);
        end
        chk({tag, " db_idle"}, bad_idle, 0);
        chk({tag, " late"}, O_LATE, e.late);
        chk({tag, " conflict"}, O_CONFLICT, e.conf);
        chk({tag, " xd_a"}, O_XD_A, t.addr);
        $display("txn %s kind=%0d addr=%02h w=%0d d=%0d oe=%0d late=%0b", tag, t.kind, t.addr, t.w, t.d, oe_cnt, O_LATE);
    endtask

    vec_t vt [9];

    initial begin
        txn_t t;
        exp_t e;

        for (int i = 0; i < (1 << ROM_AW); i++) rom[i] = 8'($urandom);
        rom[11'h53C] = 8'hA7;
        I_DB = 8'h00; I_P2 = 8'h00;

        vt[0] = '{'{0, 8'h3C, 8'h05, 6, 0, 8'h00, 1'b0, 1'b0}, '{1, 0, 0, 4, 3, 8'hA7, 1'b0, 1'b0}};
        vt[1] = '{'{1, 8'h80, 8'h00, 6, 2, 8'h5A, 1'b0, 1'b0}, '{0, 1, 0, 3, 4, 8'h5A, 1'b0, 1'b0}};
        vt[2] = '{'{2, 8'h10, 8'h00, 5, 0, 8'h00, 1'b0, 1'b0}, '{0, 0, 1, 0, 0, 8'h99, 1'b0, 1'b0}};
        vt[3] = '{'{0, 8'h3C, 8'h05, 6, 0, 8'h00, 1'b0, 1'b1}, '{1, 0, 0, 4, 3, 8'hA7, 1'b0, 1'b1}};
        vt[4] = '{'{0, 8'h20, 8'h01, 2, 0, 8'h00, 1'b0, 1'b0}, '{1, 0, 0, 0, 0, 8'h00, 1'b1, 1'b0}};
        vt[5] = '{'{1, 8'h44, 8'h00, 3, 3, 8'h66, 1'b0, 1'b0}, '{0, 1, 0, 0, 0, 8'h00, 1'b1, 1'b0}};
        vt[6] = '{'{0, 8'h3C, 8'hFD, 5, 0, 8'h00, 1'b1, 1'b0}, '{1, 0, 0, 3, 3, 8'hA7, 1'b0, 1'b0}};
        vt[7] = '{'{1, 8'hC0, 8'h00, 5, 1, 8'hC3, 1'b0, 1'b0}, '{0, 1, 0, 3, 3, 8'hC3, 1'b0, 1'b0}};
        vt[8] = '{'{2, 8'h7F, 8'h00, 1, 0, 8'h00, 1'b0, 1'b0}, '{0, 0, 1, 0, 0, 8'h4E, 1'b0, 1'b0}};

        // Reset state, checked while reset is held.
        I_RSTn = 1'b0; I_ALE = 1'b0; I_PSENn = 1'b1; I_RDn = 1'b1; I_WRn = 1'b1;
        I_XRD_ACK = 1'b0; I_XRD_D = 8'h00;
        step(); step();
        chk("reset db", O_DB, 8'hFF);
        chk("reset oe", O_DB_OE, 0);
        chk("reset rom_a", O_ROM_A, 0);
        chk("reset rom_re", O_ROM_RE, 0);
        chk("reset xd_a", O_XD_A, 0);
        chk("reset strobes", {O_XRD_REQ, O_XWR_STB}, 0);
        chk("reset xwr_d", O_XWR_D, 0);
        chk("reset flags", {O_CONFLICT, O_LATE}, 0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            if (vt[i].t.kind == 2) for (int k = 0; k < 16; k++) db_seq[k] = vt[i].e.data;
            run_txn(vt[i].t, vt[i].e, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            do_reset();
            t.kind = int'($urandom_range(0, 2));
            t.addr = 8'($urandom);
            t.p2 = 8'($urandom);
            t.d = 0; t.xd = 8'($urandom); t.dual = 1'b0; t.same_edge = 1'b0;
            if (t.kind == 0) begin
                t.w = int'($urandom_range(0, 5));
                t.w = (t.w < 2) ? t.w + 1 : t.w + 2;
                t.same_edge = 1'($urandom);
                t.dual = 1'($urandom);
            end else if (t.kind == 1) begin
                t.d = int'($urandom_range(1, 4));
                t.w = int'($urandom_range(1, 8));
                t.same_edge = 1'($urandom);
            end else begin
                t.w = int'($urandom_range(1, 6));
            end
            for (int k = 0; k < 16; k++) db_seq[k] = 8'($urandom);
            e = model(t);
            run_txn(t, e, $sformatf("rnd%0d", i));
        end

        // ALE rising during DRIVE aborts the cycle and flags it late.
        do_reset();
        latch_addr(8'h3C, 8'h05);
        I_PSENn = 1'b0;
        clear_mon();
        repeat (4) step();
        chk("abort oe_before", O_DB_OE, 1);
        chk("abort db_before", O_DB, 8'hA7);
        I_ALE = 1'b1;
        step();
        chk("abort oe", O_DB_OE, 0);
        chk("abort late", O_LATE, 1);
        chk("abort db", O_DB, 8'hFF);
        I_ALE = 1'b0; I_PSENn = 1'b1;
        repeat (3) step();
        chk("abort oe_cycles", oe_cnt, 2);
        $display("txn abort_ale oe=%0d late=%0b", oe_cnt, O_LATE);

        // Async reset during DRIVE, strobe still low at release.
        do_reset();
        latch_addr(8'h3C, 8'h05);
        I_PSENn = 1'b0; I_RDn = 1'b0;
        clear_mon();
        repeat (4) step();
        chk("rst_drive oe_before", O_DB_OE, 1);
        chk("rst_drive conflict_before", O_CONFLICT, 1);
        I_RSTn = 1'b0;
        #1;
        chk("rst_drive db", O_DB, 8'hFF);
        chk("rst_drive oe", O_DB_OE, 0);
        chk("rst_drive flags", {O_CONFLICT, O_LATE}, 0);
        I_RDn = 1'b1;
        step(); step();
        I_RSTn = 1'b1;
        clear_mon();
        repeat (4) step();
        I_PSENn = 1'b1;
        repeat (3) step();
        chk("rst_drive no_re", re_cnt, 0);
        chk("rst_drive no_oe", oe_cnt, 0);
        chk("rst_drive no_req", req_cnt, 0);
        chk("rst_drive conflict_after", O_CONFLICT, 0);
        $display("txn reset_in_drive re=%0d oe=%0d", re_cnt, oe_cnt);

        // Async reset during XWR: no strobe once WRn rises after release.
        do_reset();
        latch_addr(8'h10, 8'h00);
        I_WRn = 1'b0; I_DB = 8'h99;
        clear_mon();
        repeat (2) step();
        I_RSTn = 1'b0;
        #1;
        chk("rst_xwr stb", O_XWR_STB, 0);
        chk("rst_xwr data", O_XWR_D, 0);
        step();
        I_RSTn = 1'b1;
        repeat (2) step();
        I_WRn = 1'b1;
        repeat (3) step();
        chk("rst_xwr no_stb", stb_cnt, 0);
        chk("rst_xwr no_oe", oe_cnt, 0);
        chk("rst_xwr data_after", O_XWR_D, 0);
        $display("txn reset_in_xwr stb=%0d", stb_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
